// File: rtl/cam_capture.sv
// rtl/cam_capture.sv - camera byte stream capture into an 8-bit frame buffer
module cam_capture #(
    parameter int WIDTH  = 176,
    parameter int HEIGHT = 144,
    parameter int ADDR_W = 15,
    parameter int MODE   = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              EN,
    input  logic              PCLK,
    input  logic              HREF,
    input  logic              VSYNC,
    input  logic [7:0]        D,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [7:0]        W_DATA,
    output logic              W_EN,
    output logic              FRAME_DONE,
    output logic              OVERFLOW,
    output logic              BUSY
);

    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam logic [XW-1:0]     X_MAX     = XW'(WIDTH);
    localparam logic [YW-1:0]     Y_MAX     = YW'(HEIGHT);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VSYNC,
        ST_ACTIVE
    } state_t;

    state_t state;

    // [0] first sync flop, [1] synchronized value, [2] delayed copy for edge detect
    logic [2:0] pclk_sr;
    logic [2:0] href_sr;
    logic [2:0] vsync_sr;
    logic [7:0] d_s1;
    logic [7:0] d_s2;

    logic pclk_rise;
    logic href_rise;
    logic href_fall;
    logic vsync_rise;
    logic vsync_fall;

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] line_base;
    logic              phase;
    logic [7:0]        b1;
    logic [7:0]        pixel;

    assign pclk_rise  =  pclk_sr[1]  & ~pclk_sr[2];
    assign href_rise  =  href_sr[1]  & ~href_sr[2];
    assign href_fall  = ~href_sr[1]  &  href_sr[2];
    assign vsync_rise =  vsync_sr[1] & ~vsync_sr[2];
    assign vsync_fall = ~vsync_sr[1] &  vsync_sr[2];

    assign BUSY = (state != ST_IDLE);

    // Bring the camera strobes and data into the CLK domain
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            pclk_sr  <= '0;
            href_sr  <= '0;
            vsync_sr <= '0;
            d_s1     <= '0;
            d_s2     <= '0;
        end else begin
            pclk_sr  <= {pclk_sr[1:0], PCLK};
            href_sr  <= {href_sr[1:0], HREF};
            vsync_sr <= {vsync_sr[1:0], VSYNC};
            d_s1     <= D;
            d_s2     <= d_s1;
        end
    end

    // Pack the held first byte and the current second byte into RGB332 or luma
    always_comb begin
        pixel = d_s2;
        if (MODE == 0) begin
            pixel = {b1[7:5], b1[2:0], d_s2[4:3]};
        end else if (MODE == 1) begin
            pixel = {b1[3:1], d_s2[7:5], d_s2[3:2]};
        end
    end

    // Frame state machine, pixel assembly and write-port registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
            phase      <= 1'b0;
            b1         <= '0;
            W_ADDR     <= '0;
            W_DATA     <= '0;
            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else begin
            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (EN) begin
                        state <= ST_WAIT_VSYNC;
                    end
                end
                ST_WAIT_VSYNC: begin
                    // Only a VSYNC fall starts a frame, so a frame already under way is skipped
                    if (vsync_fall) begin
                        state     <= ST_ACTIVE;
                        x         <= '0;
                        y         <= '0;
                        line_base <= '0;
                        phase     <= 1'b0;
                        OVERFLOW  <= 1'b0;
                    end else if (!EN) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (vsync_rise) begin
                        FRAME_DONE <= 1'b1;
                        state      <= EN ? ST_WAIT_VSYNC : ST_IDLE;
                    end else begin
                        // An unpaired byte left at line end is dropped by clearing the phase
                        if (href_rise || href_fall) begin
                            phase <= 1'b0;
                        end
                        if (href_fall && (x != '0)) begin
                            x <= '0;
                            // y stops at HEIGHT so later lines can never alias valid rows
                            if (y < Y_MAX) begin
                                y         <= y + 1'b1;
                                line_base <= line_base + LINE_STEP;
                            end
                        end else if (pclk_rise && href_sr[1]) begin
                            if (!phase) begin
                                b1    <= d_s2;
                                phase <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                if ((x < X_MAX) && (y < Y_MAX)) begin
                                    W_EN   <= 1'b1;
                                    W_ADDR <= line_base + ADDR_W'(x);
                                    W_DATA <= pixel;
                                end else begin
                                    OVERFLOW <= 1'b1;
                                end
                                if (x < X_MAX) begin
                                    x <= x + 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// tb/tb_cam_capture.sv - randomized frame capture bench for cam_capture in all three modes
module tb_cam_capture;

    localparam int W  = 16;
    localparam int H  = 12;
    localparam int AW = 8;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          EN;
    logic          PCLK;
    logic          HREF;
    logic          VSYNC;
    logic [7:0]    D;

    logic [AW-1:0] w_addr     [3];
    logic [7:0]    w_data     [3];
    logic          w_en       [3];
    logic          frame_done [3];
    logic          overflow   [3];
    logic          busy       [3];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cam_capture #(
            .WIDTH (W),
            .HEIGHT(H),
            .ADDR_W(AW),
            .MODE  (g)
        ) dut (
            .CLK       (CLK),
            .RESET_N   (RESET_N),
            .EN        (EN),
            .PCLK      (PCLK),
            .HREF      (HREF),
            .VSYNC     (VSYNC),
            .D         (D),
            .W_ADDR    (w_addr[g]),
            .W_DATA    (w_data[g]),
            .W_EN      (w_en[g]),
            .FRAME_DONE(frame_done[g]),
            .OVERFLOW  (overflow[g]),
            .BUSY      (busy[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: pixel packing from the colour-format rules, written as arithmetic
    function automatic logic [7:0] fmt(input int mode, input logic [7:0] b1, input logic [7:0] b2);
        int r, gr, bl;
        if (mode == 0) begin
            r  = int'(b1) / 32;
            gr = int'(b1) % 8;
            bl = (int'(b2) / 8) % 4;
        end else if (mode == 1) begin
            r  = (int'(b1) % 16) / 2;
            gr = int'(b2) / 32;
            bl = (int'(b2) % 16) / 4;
        end else begin
            return b2;
        end
        return 8'(r * 32 + gr * 4 + bl);
    endfunction

    logic [15:0] exp_q [3][$];
    int          fd_cnt [3];
    bit          ovf_exp = 1'b0;

    // Scoreboard: every write must match the next expected {addr, data} for its mode
    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            if (frame_done[k] === 1'b1) fd_cnt[k]++;
            if (w_en[k] === 1'b1) begin
                if (exp_q[k].size() == 0) begin
                    check($sformatf("m%0d write with none expected, addr", k), 32'(w_addr[k]), 32'hFFFF_FFFF);
                end else begin
                    logic [15:0] e;
                    e = exp_q[k].pop_front();
                    check($sformatf("m%0d w_addr", k), 32'(w_addr[k]), 32'(e[15:8]));
                    check($sformatf("m%0d w_data", k), 32'(w_data[k]), 32'(e[7:0]));
                end
            end
        end
    end

    task automatic tick(input logic href, input logic [7:0] d);
        PCLK = 1'b0;
        HREF = href;
        D    = d;
        #20;
        PCLK = 1'b1;
        #20;
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s m%0d w_addr", tag, k), 32'(w_addr[k]), 0);
            check($sformatf("%s m%0d w_data", tag, k), 32'(w_data[k]), 0);
            check($sformatf("%s m%0d w_en", tag, k), 32'(w_en[k]), 0);
            check($sformatf("%s m%0d frame_done", tag, k), 32'(frame_done[k]), 0);
            check($sformatf("%s m%0d overflow", tag, k), 32'(overflow[k]), 0);
            check($sformatf("%s m%0d busy", tag, k), 32'(busy[k]), 0);
        end
    endtask

    // One camera frame: VSYNC fall, nl lines of np pixels, VSYNC rise.
    // ev_kind at the start of line ev_line: 1 drop EN, 2 raise EN, 3 one-CLK reset.
    task automatic frame(input string name, input int nl, input int np, input bit odd,
                         input int ev_line, input int ev_kind);
        bit          cap;
        logic [7:0]  b1, b2;
        for (int k = 0; k < 3; k++) fd_cnt[k] = 0;
        VSYNC = 1'b0;
        cap   = EN;
        if (cap) ovf_exp = 1'b0;
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        if (cap) begin
            for (int k = 0; k < 3; k++)
                check($sformatf("%s m%0d overflow at start", name, k), 32'(overflow[k]), 0);
        end
        for (int l = 0; l < nl; l++) begin
            if (l == ev_line) begin
                if (ev_kind == 1) EN = 1'b0;
                if (ev_kind == 2) EN = 1'b1;
                if (ev_kind == 3) begin
                    @(negedge CLK);
                    RESET_N = 1'b0;
                    @(posedge CLK);
                    #1;
                    check_all_zero($sformatf("%s reset", name));
                    RESET_N = 1'b1;
                    cap     = 1'b0;
                    ovf_exp = 1'b0;
                end
            end
            for (int p = 0; p < np; p++) begin
                b1 = 8'($urandom);
                b2 = 8'($urandom);
                if (cap) begin
                    if (p < W && l < H) begin
                        for (int k = 0; k < 3; k++)
                            exp_q[k].push_back({8'(l * W + p), fmt(k, b1, b2)});
                    end else begin
                        ovf_exp = 1'b1;
                    end
                end
                tick(1'b1, b1);
                tick(1'b1, b2);
            end
            if (odd && $urandom_range(0, 1) == 1) tick(1'b1, 8'($urandom));
            for (int i = 0; i < 3; i++) tick(1'b0, 8'($urandom));
        end
        VSYNC = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s m%0d pending writes", name, k), 32'(exp_q[k].size()), 0);
            check($sformatf("%s m%0d frame_done pulses", name, k), 32'(fd_cnt[k]), 32'(cap));
            check($sformatf("%s m%0d overflow", name, k), 32'(overflow[k]), 32'(ovf_exp));
            check($sformatf("%s m%0d busy", name, k), 32'(busy[k]), 32'(EN));
            exp_q[k].delete();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0;
        EN      = 1'b0;
        PCLK    = 1'b0;
        HREF    = 1'b0;
        VSYNC   = 1'b1;
        D       = 8'h00;
        repeat (5) @(posedge CLK);
        #1;
        check_all_zero("power-on reset");
        RESET_N = 1'b1;

        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00);
        for (int k = 0; k < 3; k++) check($sformatf("idle m%0d busy", k), 32'(busy[k]), 0);
        EN = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00);
        for (int k = 0; k < 3; k++) check($sformatf("armed m%0d busy", k), 32'(busy[k]), 1);

        frame("full",         H,     W,     1'b0, -1, 0);
        frame("odd_bytes",    H,     W,     1'b1, -1, 0);
        frame("oversize",     H + 2, W + 2, 1'b1, -1, 0);
        frame("after_ovf",    H,     W,     1'b0, -1, 0);
        frame("en_drop",      H,     W,     1'b0,  3, 1);
        frame("disabled",     H,     W,     1'b0, -1, 0);
        frame("en_mid_frame", H,     W,     1'b0,  5, 2);
        frame("resumed",      H,     W,     1'b0, -1, 0);
        frame("reset_mid",    H,     W,     1'b0,  7, 3);
        frame("after_reset",  H,     W,     1'b1, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
